mem_copy_engine: RTL and testbench
==================================

// Module: mem_copy_engine
// PURPOSE
//  Initiator-side master for the byte-wide data memory port: addr, dat_in, wr_en, dat_out, done.
//  Copies LEN bytes from SRC to DST. Reads are combinational; each write waits for the memory done ack.
//  Sits between the control FSM and the data memory; the control side uses a start/busy/done handshake.
// PARAMETERS
//  AW          8   address width (memory depth 2**AW)
//  DW          8   data width
//  ACK_TIMEOUT 15  max WAIT_ACK cycles before abort (>=1)
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   request copy; sampled only in IDLE
//  src_addr    in   AW  source base address
//  dst_addr    in   AW  destination base address
//  len         in   AW  byte count; 0 = no-op
//  busy        out  1   high in every state except IDLE
//  done        out  1   1-cycle pulse in FINISH
//  err         out  1   sticky ack-timeout flag
//  mem_addr    out  AW  memory address
//  mem_dat_in  out  DW  memory write data
//  mem_wr_en   out  1   memory write enable
//  mem_dat_out in   DW  memory read data (combinational from mem_addr)
//  mem_done    in   1   memory write ack, registered one cycle after a wr_en edge
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; idx, data reg and timeout count = 0.
//   - busy, done, err, mem_wr_en = 0; mem_addr, mem_dat_in = 0.
//   - Mid-copy reset aborts immediately; bytes already written stay in memory.
//  Memory-side outputs are decoded from registered state only (no input-to-output paths).
//  Each byte takes 3 states:
//   - READ: mem_addr=src+idx; mem_dat_out captured into data reg at edge.
//   - WRITE: mem_addr=dst+idx, mem_wr_en=1, mem_dat_in=data reg.
//   - WAIT_ACK: mem_wr_en=0, mem_addr held at dst+idx.
//  Transitions:
//   - IDLE: start=1 latches src/dst/len, clears err and idx; ->READ, or ->FINISH if len=0.
//   - READ->WRITE; WRITE->WAIT_ACK.
//   - WAIT_ACK, mem_done=1: idx++; ->FINISH if idx+1==len, else ->READ.
//   - WAIT_ACK, no ack: count++; at count==ACK_TIMEOUT set err, ->FINISH (abort).
//   - WAIT_ACK, ack in the same cycle as the limit: ack wins, err not set.
//   - FINISH: done=1 for one cycle; ->IDLE.
//  Latency: start sampled at edge E0 -> done high in cycle 3*len+1 after E0; len=0 -> cycle 1.
//  Address arithmetic is mod 2**AW; src+idx and dst+idx wrap silently.
//  Overlap: strict forward byte order, each byte read just before it is written.
//   - dst=src+1 therefore replicates byte[src] across the range (defined, tested).
//  start while busy is ignored (no queueing). A mem_done outside WAIT_ACK is ignored.
//  Inputs src_addr, dst_addr, len may change freely after the start cycle.
// CONFIGURATION
//  MEMCPY_FILL_EN defined:
//   - Adds ports fill_mode (in, 1) and fill_val (in, DW), latched with start.
//   - fill_mode=1 skips READ: WRITE of fill_val to dst+idx, then WAIT_ACK; latency 2*len+1.
//  Not defined: ports absent; copy only; behaviour as above.
// TESTING
//  - Preload mem[0x10..0x13]=A1,B2,C3,D4; start src=10 dst=80 len=4
//    -> mem[0x80..0x83]=A1,B2,C3,D4; done exactly 13 cycles after start edge; err=0.
//  - len=0 -> done pulse in the next cycle; mem_wr_en never asserted; busy high 1 cycle.
//  - src=FE dst=20 len=4 with mem[FE,FF,00,01]=1,2,3,4 -> mem[20..23]=1,2,3,4 (wrap).
//  - Hold mem_done=0 -> err=1 after ACK_TIMEOUT=15 WAIT cycles; done pulses; next start clears err.
//  - Pulse rst_n low mid-copy (byte 2 of 4) -> busy=0 and mem_wr_en=0 immediately;
//    mem[dst+2..] unchanged; start during busy has no effect.
//  - MEMCPY_FILL_EN: fill_mode=1, fill_val=5A, dst=40, len=3 -> mem[40..42]=5A; done at cycle 7.

Source files
------------

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies len bytes from src_addr to dst_addr over a byte-wide memory port.
// Ports:
//   clk, rst_n (async, active-low)
//   start, src_addr, dst_addr, len   control request
//   busy, done, err                  control status
//   mem_addr, mem_dat_in, mem_wr_en  memory request
//   mem_dat_out, mem_done            memory response
// Optional build macro MEMCPY_FILL_EN adds fill_mode/fill_val for a memset-style fill.
module mem_copy_engine #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
`ifdef MEMCPY_FILL_EN
    input  logic          fill_mode,
    input  logic [DW-1:0] fill_val,
`endif
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat_in,
    output logic          mem_wr_en,
    input  logic [DW-1:0] mem_dat_out,
    input  logic          mem_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam int          CW    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT - 1);

    logic [2:0]    state;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [AW-1:0] len_q;
    logic [AW-1:0] idx;
    logic [DW-1:0] data_q;
    logic [CW-1:0] cnt;
    logic          err_q;
    logic          fill_q;
    logic          fill_start;
    logic [DW-1:0] fill_data;

`ifdef MEMCPY_FILL_EN
    assign fill_start = fill_mode;
    assign fill_data  = fill_val;
`else
    assign fill_start = 1'b0;
    assign fill_data  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            idx    <= '0;
            data_q <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
            fill_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_q  <= src_addr;
                        dst_q  <= dst_addr;
                        len_q  <= len;
                        idx    <= '0;
                        cnt    <= '0;
                        err_q  <= 1'b0;
                        fill_q <= fill_start;
                        // Fill mode never enters READ, so the data reg holds the fill byte.
                        if (fill_start)
                            data_q <= fill_data;
                        if (len == '0)
                            state <= S_FINISH;
                        else if (fill_start)
                            state <= S_WRITE;
                        else
                            state <= S_READ;
                    end
                end
                S_READ: begin
                    data_q <= mem_dat_out;
                    state  <= S_WRITE;
                end
                S_WRITE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // An ack arriving on the limit cycle still completes the byte.
                    if (mem_done) begin
                        idx <= idx + AW'(1);
                        if ((idx + AW'(1)) == len_q)
                            state <= S_FINISH;
                        else if (fill_q)
                            state <= S_WRITE;
                        else
                            state <= S_READ;
                    end else if (cnt == LIMIT) begin
                        err_q <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Outputs depend on registered state only.
    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_FINISH);
        err        = err_q;
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_dat_in = '0;
        case (state)
            S_READ: mem_addr = src_q + idx;
            S_WRITE: begin
                mem_addr   = dst_q + idx;
                mem_wr_en  = 1'b1;
                mem_dat_in = data_q;
            end
            S_WAIT: mem_addr = dst_q + idx;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed test of mem_copy_engine against a byte memory model.
// Memory acks each write one cycle after wr_en unless ack_en is low.
module tb_mem_copy_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] src_addr = '0;
    logic [7:0] dst_addr = '0;
    logic [7:0] len = '0;
    logic       fill_mode = 1'b0;
    logic [7:0] fill_val = '0;
    logic       busy, done, err;
    logic [7:0] mem_addr, mem_dat_in, mem_dat_out;
    logic       mem_wr_en;
    logic       mem_done = 1'b0;
    logic       ack_en = 1'b1;

    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int busy_cnt = 0;
    int cyc;

    always #5 clk = ~clk;

    mem_copy_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
`ifdef MEMCPY_FILL_EN
        .fill_mode(fill_mode), .fill_val(fill_val),
`endif
        .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_dat_in(mem_dat_in),
        .mem_wr_en(mem_wr_en), .mem_dat_out(mem_dat_out),
        .mem_done(mem_done)
    );

    assign mem_dat_out = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en)
            mem[mem_addr] <= mem_dat_in;
        mem_done <= mem_wr_en & ack_en;
    end

    always @(negedge clk) begin
        if (mem_wr_en) wr_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Issue a request and count cycles from the start edge until done is seen.
    task automatic do_copy(input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, output int n);
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        src_addr = 8'h00; dst_addr = 8'h00; len = 8'h00;
        n = 1;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_wr_en", mem_wr_en, 1'b0);
        check("rst_addr", mem_addr, 8'h00);
        check("rst_dat_in", mem_dat_in, 8'h00);
        @(negedge clk); rst_n = 1'b1;

        // Basic copy
        mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2;
        mem[8'h12] = 8'hC3; mem[8'h13] = 8'hD4;
        do_copy(8'h10, 8'h80, 8'd4, cyc);
        check("copy_lat", cyc, 13);
        check("copy_done", done, 1'b1);
        check("copy_err", err, 1'b0);
        @(posedge clk); #1;
        check("done_pulse", done, 1'b0);
        check("copy_b0", mem[8'h80], 8'hA1);
        check("copy_b1", mem[8'h81], 8'hB2);
        check("copy_b2", mem[8'h82], 8'hC3);
        check("copy_b3", mem[8'h83], 8'hD4);

        // Zero length
        @(negedge clk); wr_cnt = 0; busy_cnt = 0;
        do_copy(8'h10, 8'h60, 8'd0, cyc);
        check("len0_lat", cyc, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("len0_wr", wr_cnt, 0);
        check("len0_busy", busy_cnt, 1);

        // Address wrap
        mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02;
        mem[8'h00] = 8'h03; mem[8'h01] = 8'h04;
        do_copy(8'hFE, 8'h20, 8'd4, cyc);
        check("wrap_lat", cyc, 13);
        @(posedge clk); #1;
        check("wrap_b0", mem[8'h20], 8'h01);
        check("wrap_b1", mem[8'h21], 8'h02);
        check("wrap_b2", mem[8'h22], 8'h03);
        check("wrap_b3", mem[8'h23], 8'h04);

        // Overlap dst=src+1 replicates the first byte forward
        mem[8'h30] = 8'h11; mem[8'h31] = 8'h22;
        mem[8'h32] = 8'h33; mem[8'h33] = 8'h44;
        do_copy(8'h30, 8'h31, 8'd3, cyc);
        @(posedge clk); #1;
        check("ovl_b1", mem[8'h31], 8'h11);
        check("ovl_b2", mem[8'h32], 8'h11);
        check("ovl_b3", mem[8'h33], 8'h11);

        // Ack timeout: first byte aborts after 15 wait cycles
        ack_en = 1'b0;
        do_copy(8'h10, 8'hA0, 8'd2, cyc);
        check("to_lat", cyc, 18);
        check("to_err", err, 1'b1);
        @(posedge clk); #1;
        check("to_sticky", err, 1'b1);
        check("to_idle", busy, 1'b0);
        ack_en = 1'b1;
        @(negedge clk);
        src_addr = 8'h10; dst_addr = 8'hA0; len = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("to_clear", err, 1'b0);
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("len1_lat", cyc, 4);
        @(posedge clk); #1;

        // Mid-copy reset, with an ignored start while busy
        for (int i = 0; i < 4; i++) mem[8'h90 + i] = 8'hEE;
        for (int i = 0; i < 4; i++) mem[8'h50 + i] = 8'h77;
        @(negedge clk);
        src_addr = 8'h10; dst_addr = 8'h90; len = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 3) begin @(posedge clk); #1; cyc++; end
        src_addr = 8'h50; dst_addr = 8'h92; len = 8'd1; start = 1'b1;
        @(posedge clk); #1; cyc++;
        start = 1'b0;
        while (cyc < 7) begin @(posedge clk); #1; cyc++; end
        check("mid_read_addr", mem_addr, 8'h12);
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 1'b0);
        check("mid_wr_en", mem_wr_en, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_b0", mem[8'h90], 8'hA1);
        check("mid_b1", mem[8'h91], 8'hB2);
        check("mid_b2", mem[8'h92], 8'hEE);
        check("mid_b3", mem[8'h93], 8'hEE);

`ifdef MEMCPY_FILL_EN
        fill_mode = 1'b1; fill_val = 8'h5A;
        do_copy(8'h00, 8'h40, 8'd3, cyc);
        fill_mode = 1'b0;
        check("fill_lat", cyc, 7);
        @(posedge clk); #1;
        check("fill_b0", mem[8'h40], 8'h5A);
        check("fill_b1", mem[8'h41], 8'h5A);
        check("fill_b2", mem[8'h42], 8'h5A);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
